// File: rtl/axi4stream_slv_sink.sv
`default_nettype none
// ============================================================================
// Module  : axi4stream_slv_sink
// Brief   : AXI4-Stream slave endpoint with FWFT FIFO, LFSR backpressure,
//           beat counter and running checksum.
// Revision: 1.0 - initial release
// ============================================================================
module axi4stream_slv_sink #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     thr_en,
  input  logic [7:0]               thr_level,
  input  logic                     clr,
  output logic [CNT_WIDTH-1:0]     beat_cnt,
  output logic [DATA_WIDTH-1:0]    chksum
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_MAX = DEPTH[AW:0];

  logic [AW:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] last_q;
  logic [7:0]            lfsr_q, lfsr_d;
  logic                  rdy_en_q;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0] chksum_q, chksum_d;

  logic full, empty, throttle, push, pop, lfsr_fb;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign throttle = thr_en && (lfsr_q < thr_level);
  // rdy_en_q keeps tready low while reset is held, independent of throttle state
  assign s_axis_tready = rdy_en_q && !full && !throttle && !clr;
  assign push     = s_axis_tvalid && s_axis_tready;
  assign rd_valid = !empty;
  assign pop      = rd_en && rd_valid;
  assign level    = wptr_q - rptr_q;
  assign rd_data  = rd_valid ? mem_q[rptr_q[AW-1:0]] : last_q;
  assign beat_cnt = beat_cnt_q;
  assign chksum   = chksum_q;
  assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    beat_cnt_d = beat_cnt_q;
    chksum_d   = chksum_q;
    lfsr_d     = thr_en ? {lfsr_q[6:0], lfsr_fb} : lfsr_q;
    if (clr) begin
      wptr_d     = '0;
      rptr_d     = '0;
      beat_cnt_d = '0;
      chksum_d   = '0;
    end else begin
      if (push) begin
        wptr_d     = wptr_q + 1'b1;
        beat_cnt_d = beat_cnt_q + 1'b1;
        chksum_d   = chksum_q + s_axis_tdata;
      end
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      lfsr_q     <= 8'h01;
      rdy_en_q   <= 1'b0;
      beat_cnt_q <= '0;
      chksum_q   <= '0;
      last_q     <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      lfsr_q     <= lfsr_d;
      rdy_en_q   <= 1'b1;
      beat_cnt_q <= beat_cnt_d;
      chksum_q   <= chksum_d;
      if (rd_valid) begin
        last_q <= mem_q[rptr_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= s_axis_tdata;
    end
  end

`ifndef SYNTHESIS
  logic                  chk_vld_q, chk_rdy_q;
  logic [DATA_WIDTH-1:0] chk_data_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      chk_vld_q  <= 1'b0;
      chk_rdy_q  <= 1'b0;
      chk_data_q <= '0;
    end else begin
      chk_vld_q  <= s_axis_tvalid;
      chk_rdy_q  <= s_axis_tready;
      chk_data_q <= s_axis_tdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (aresetn) begin
      if (chk_vld_q && !chk_rdy_q) begin
        assert (s_axis_tvalid) else $error("tvalid dropped before acceptance");
        assert (s_axis_tdata == chk_data_q) else $error("tdata changed while stalled");
      end
      assert (level <= LVL_MAX) else $error("level exceeds DEPTH");
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/axi4stream_slv_sink.md
Name: axi4stream_slv_sink

Overview:
- Synthesizable AXI4-Stream slave endpoint: the receiving end for the 8-bit, TREADY-capable, no-TLAST stream driven by the team's AXI4-Stream master agent in DUT-level benches.
- Accepts beats into a first-word-fall-through FIFO and exposes them on a simple pull port.
- Optionally throttles TREADY with an LFSR so backpressure is stress-tested.
- Keeps a beat counter and a running checksum for end-of-test comparison.

Parameters:
DATA_WIDTH, 8, TDATA width in bits
DEPTH, 16, FIFO entries; power of two, at least 2
CNT_WIDTH, 32, beat counter width

Ports:
aclk  in  1  clock; single clock domain
aresetn  in  1  asynchronous active-low reset
s_axis_tvalid  in  1  stream valid
s_axis_tready  out  1  stream ready
s_axis_tdata  in  DATA_WIDTH  stream data
rd_en  in  1  pop request
rd_valid  out  1  FIFO head valid (not empty)
rd_data  out  DATA_WIDTH  FIFO head data (FWFT)
level  out  log2(DEPTH)+1  current occupancy, 0..DEPTH
thr_en  in  1  enable LFSR backpressure
thr_level  in  8  throttle threshold
clr  in  1  synchronous clear of FIFO, counters and checksum
beat_cnt  out  CNT_WIDTH  accepted beats; wraps modulo 2^CNT_WIDTH
chksum  out  DATA_WIDTH  sum of accepted tdata, modulo 2^DATA_WIDTH

Behaviour:
- Reset (aresetn low, asynchronous):
  - Outputs: s_axis_tready=0, rd_valid=0, rd_data=0, level=0, beat_cnt=0, chksum=0.
  - Internal state: pointers=0, LFSR=8'h01.
  - Release is synchronous to aclk. tready may rise in the first cycle after release.
- Handshake:
  - Beat accepted on a rising aclk edge with tvalid&&tready.
  - tready = !full && !throttle && !clr.
  - tready is a function of registered state and clr only. It never depends combinationally on tvalid.
  - tready may drop without tvalid being high.
  - Unaccepted tvalid/tdata are not sampled.
- Throttle:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, shifts every cycle while thr_en=1 and holds otherwise.
  - throttle = thr_en && (lfsr < thr_level).
  - thr_level=0 means never throttle.
  - The LFSR never reaches 0, so thr_level=255 gives ready at most 1 cycle in 255.
- FIFO:
  - Accepted beat is written at wptr. It becomes visible on rd_valid/rd_data the cycle after acceptance (latency 1).
  - rd_valid = (level != 0). rd_data = mem[rptr] whenever rd_valid=1; otherwise rd_data holds its last value.
  - Pop when rd_en&&rd_valid. rd_en with rd_valid=0 is ignored: no pointer change, no error.
  - Pointers are log2(DEPTH)+1 bits with an extra wrap bit. full = MSBs differ and LSBs equal; empty = equal.
- Simultaneous events:
  - Push and pop in the same cycle: level unchanged, both pointers advance.
  - When full, tready=0, so a pop frees exactly one slot. tready rises the next cycle (if not throttled).
  - Pop of the last entry together with a push: rd_valid stays 1 and presents the new beat next cycle.
- Counters:
  - beat_cnt increments by 1 per accepted beat and wraps to 0 after all-ones.
  - chksum += tdata per accepted beat, truncated to DATA_WIDTH.
- clr:
  - Takes effect at the clock edge. Empties the FIFO and zeroes level, beat_cnt and chksum.
  - tready=0 during the clr cycle, so no beat is lost or half-counted.
  - The LFSR is unaffected.
- Reset mid-operation: all FIFO contents are discarded. A master with tvalid held high sees tready=0 until reset release.
- Assertions (sim only):
  - Flag a tdata change while tvalid&&!tready.
  - Flag tvalid deasserting before acceptance.
  - Flag level > DEPTH.

Test Plan:
- Reset, thr_en=0, send bytes 0x01..0x05 back-to-back, rd_en=1 → rd_data 0x01..0x05 in order, each 1 cycle after its accept; beat_cnt=5, chksum=0x0F.
- Fill without reading: 16 beats 0xA0..0xAF, rd_en=0 → tready low after the 16th accept, level=16; one pop → tready high next cycle, 17th beat accepted, level returns to 16.
- Simultaneous push/pop at level=1 for 100 cycles with incrementing data → level stays 1, no data loss, order preserved, beat_cnt=101 total.
- thr_en=1, thr_level=128, 1000 random beats with master random tvalid → all data received in order; tready duty about 50%; no tready change driven by tvalid (checked at tvalid toggles).
- 256 beats of 0xFF → chksum=0x00, beat_cnt=256; then clr pulse with tvalid high → tready=0 that cycle, beat_cnt=0, chksum=0, level=0, next beat counted normally.
- aresetn asserted asynchronously mid-burst with level=7 → tready, rd_valid, level, beat_cnt, chksum all 0 immediately; after release the first beat returns as rd_data with level=1.
